// File: rtl/spi_xfer_ctrl_if.sv
// Bus bundle for spi_xfer_ctrl: CPU-side TX/RX FIFO handshakes, status, and the byte-engine link.
// master = CPU + engine side (drives pushes, pops, engine status); slave = the controller.
interface spi_xfer_ctrl_if #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
);
    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    logic [7:0]     tx_data;
    logic           tx_keep;
    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [TXL-1:0] tx_level;
    logic [RXL-1:0] rx_level;
    logic           idle;
    logic           err;
    logic           err_clr;
    logic [7:0]     eng_so;
    logic           eng_ex;
    logic           eng_ack;
    logic           eng_busy;
    logic [7:0]     eng_si;

    modport master (
        output tx_data, tx_keep, tx_valid, rx_ready, err_clr, eng_busy, eng_si,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level, idle, err, eng_so, eng_ex, eng_ack
    );

    modport slave (
        input  tx_data, tx_keep, tx_valid, rx_ready, err_clr, eng_busy, eng_si,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level, idle, err, eng_so, eng_ex, eng_ack
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: TX FIFO -> byte engine handshake -> RX FIFO.
// Optional REQ watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic           clk,
    input  logic           rst,
    spi_xfer_ctrl_if.slave bus
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam logic [TXA:0] TX_FULL = (TXA+1)'(TX_DEPTH);
    localparam logic [RXA:0] RX_FULL = (RXA+1)'(RX_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_CAP   = 2'd3;

    logic [1:0]   r_state;
    logic [7:0]   r_so;
    logic         r_keep;
    logic [8:0]   r_tx_mem [TX_DEPTH];
    logic [7:0]   r_rx_mem [RX_DEPTH];
    logic [TXA:0] r_tx_wp, r_tx_rp;
    logic [RXA:0] r_rx_wp, r_rx_rp;

    logic [TXA:0] w_tx_level;
    logic [RXA:0] w_rx_level;
    logic         w_tx_ready, w_rx_valid;
    logic         w_tx_push, w_rx_push, w_rx_pop;
    logic [8:0]   w_head;
    logic         w_start;
    logic         w_to_fire;

    assign w_tx_level = r_tx_wp - r_tx_rp;
    assign w_rx_level = r_rx_wp - r_rx_rp;
    assign w_tx_ready = (w_tx_level != TX_FULL);
    assign w_rx_valid = (w_rx_level != '0);
    assign w_tx_push  = bus.tx_valid & w_tx_ready;
    assign w_rx_pop   = bus.rx_ready & w_rx_valid;
    assign w_rx_push  = (r_state == S_CAP) & r_keep;
    assign w_head     = r_tx_mem[r_tx_rp[TXA-1:0]];

    // RX space is reserved here: only one byte is ever in flight, so the level seen now cannot grow before CAPTURE.
    assign w_start = (r_state == S_IDLE) && (w_tx_level != '0) &&
                     (!w_head[8] || (w_rx_level != RX_FULL));

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TXA-1:0]] <= {bus.tx_keep, bus.tx_data};
        if (w_rx_push) r_rx_mem[r_rx_wp[RXA-1:0]] <= bus.eng_si;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_start)   r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_so    <= '0;
            r_keep  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_so    <= w_head[7:0];
                    r_keep  <= w_head[8];
                    r_state <= S_REQ;
                end
                // A busy already high on entry counts as the engine having started.
                S_REQ: begin
                    if (bus.eng_busy)   r_state <= S_SHIFT;
                    else if (w_to_fire) r_state <= S_IDLE;
                end
                S_SHIFT: if (!bus.eng_busy) r_state <= S_CAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1) + 1;
    logic [TOW-1:0] r_to_cnt;
    logic           r_err;

    assign w_to_fire = (r_state == S_REQ) && !bus.eng_busy && (r_to_cnt == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_to_cnt <= '0;
        else if (r_state != S_REQ)  r_to_cnt <= '0;
        else                        r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_err <= 1'b0;
        else if (w_to_fire)   r_err <= 1'b1;
        else if (bus.err_clr) r_err <= 1'b0;
    end

    assign bus.err = r_err;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.err_clr;
    assign w_to_fire = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_valid = w_rx_valid;
    assign bus.rx_data  = r_rx_mem[r_rx_rp[RXA-1:0]];
    assign bus.tx_level = w_tx_level;
    assign bus.rx_level = w_rx_level;
    assign bus.idle     = (r_state == S_IDLE) && (w_tx_level == '0);
    assign bus.eng_so   = r_so;
    assign bus.eng_ex   = (r_state == S_REQ);
    assign bus.eng_ack  = (r_state == S_CAP);
endmodule
